// File: rtl/riscv_pkg.sv
// Shared constants and types for the decode/execute pipeline boundary.
package riscv_pkg;

  localparam int unsigned CTRL_W        = 12;
  localparam int unsigned CTRL_MEM_READ = 3;
  localparam int unsigned REG_W         = 5;
  localparam logic [REG_W-1:0] REG_X0   = 5'd0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } stage_state_e;

  // True when a non-x0 destination index matches a source index
  function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
    return (dst != REG_X0) && (dst == src);
  endfunction

endpackage

// File: rtl/load_use_hazard.sv
// Load-use hazard detect: a load held in EX whose rd feeds the instruction in decode.
module load_use_hazard
  import riscv_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             hazard_c
);

  // Stall only for a live load with a real destination that decode wants to read
  always_comb begin
    hazard_c = ex_valid & ex_mem_read &
               (reg_match(ex_rd, id_rs1) | reg_match(ex_rd, id_rs2));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with x0 forcing, load-use bubble insertion, flush,
// valid/ready on both sides and a saturating bubble counter.
// Optional writeback bypass into captured and held operands: ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
  parameter int unsigned N      = 32,
  parameter int unsigned CTRL_W = riscv_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [N-1:0]      id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [N-1:0]      id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_reg_write,
  input  logic [N-1:0]      rd1,
  input  logic [N-1:0]      rd2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [N-1:0]      wb_wd,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [N-1:0]      ex_pc,
  output logic [N-1:0]      ex_imm,
  output logic [N-1:0]      ex_op_a,
  output logic [N-1:0]      ex_op_b,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  bubble_cnt
);

  import riscv_pkg::*;

  stage_state_e   state;
  stage_state_e   state_nx;
  logic           hazard_c;
  logic           accept_c;
  logic           cnt_inc_c;
  logic [N-1:0]   op_a_c;
  logic [N-1:0]   op_b_c;

  load_use_hazard u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard_c    (hazard_c)
  );

  assign id_ready = ~rst & ~flush & ~hazard_c & (~ex_valid | ex_ready);
  assign accept_c = id_valid & id_ready;

  // Operand select: x0 reads as zero, optional same-cycle writeback forward
  always_comb begin
    op_a_c = rd1;
    op_b_c = rd2;
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_we && reg_match(wb_rd, id_rs1)) op_a_c = wb_wd;
    if (wb_we && reg_match(wb_rd, id_rs2)) op_b_c = wb_wd;
`else
    if (id_rs1 == REG_X0) op_a_c = '0;
`endif
    if (id_rs1 == REG_X0) op_a_c = '0;
    if (id_rs2 == REG_X0) op_b_c = '0;
  end

`ifndef ID_EX_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_wd};
`endif

  // Bubble FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  // Bubble FSM next state: a drained load costs exactly one cycle, flush returns to RUN
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:    if (~flush & hazard_c & ex_ready) state_nx = ST_BUBBLE;
      ST_BUBBLE: state_nx = ST_RUN;
    endcase
    if (flush) state_nx = ST_RUN;
  end

  // Bubble FSM output: count a bubble when leaving RUN for BUBBLE
  always_comb begin
    cnt_inc_c = 1'b0;
    if (state == ST_RUN) cnt_inc_c = ~flush & hazard_c & ex_ready;
  end

  // Stage register: flush kills, accept loads, drain clears valid, hold keeps data
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_rs1       <= REG_X0;
      ex_rs2       <= REG_X0;
      ex_rd        <= REG_X0;
      ex_ctrl      <= '0;
      ex_reg_write <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept_c) begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_op_a      <= op_a_c;
      ex_op_b      <= op_b_c;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_ctrl      <= id_ctrl;
      ex_reg_write <= id_reg_write & (id_rd != REG_X0);
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
`ifdef ID_EX_WB_BYPASS_EN
    end else if (ex_valid) begin
      if (wb_we && reg_match(wb_rd, ex_rs1)) ex_op_a <= wb_wd;
      if (wb_we && reg_match(wb_rd, ex_rs2)) ex_op_b <= wb_wd;
`endif
    end
  end

  // Saturating count of inserted load-use bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (cnt_inc_c && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random traffic,
// every cycle compared against a rule-level model of the stage.
module tb_id_ex_stage;

  localparam int unsigned N      = 32;
  localparam int unsigned CTRL_W = 12;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned MEMRD  = 3;

`ifdef ID_EX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic              id_ready;
  logic [N-1:0]      id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [N-1:0]      id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_reg_write;
  logic [N-1:0]      rd1;
  logic [N-1:0]      rd2;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [N-1:0]      wb_wd;
  logic              flush;
  logic              ex_valid;
  logic              ex_ready;
  logic [N-1:0]      ex_pc;
  logic [N-1:0]      ex_imm;
  logic [N-1:0]      ex_op_a;
  logic [N-1:0]      ex_op_b;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_reg_write;
  logic [CNT_W-1:0]  bubble_cnt;

  id_ex_stage #(.N(N), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_reg_write(id_reg_write),
    .rd1(rd1), .rd2(rd2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_reg_write(ex_reg_write), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Abstract contents of the stage as seen from execute
  typedef struct {
    logic              valid;
    logic [N-1:0]      pc, imm, op_a, op_b;
    logic [4:0]        rs1, rs2, rd;
    logic [CTRL_W-1:0] ctrl;
    logic              rw;
    logic [CNT_W-1:0]  cnt;
  } mdl_t;

  mdl_t m;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hazard(input mdl_t s);
    return s.valid && s.ctrl[MEMRD] && (s.rd != 5'd0) && (s.rd == id_rs1 || s.rd == id_rs2);
  endfunction

  function automatic logic model_ready(input mdl_t s);
    return !rst && !flush && !model_hazard(s) && (!s.valid || ex_ready);
  endfunction

  // Operand an instruction should carry into execute, given the current register reads
  function automatic logic [N-1:0] pick_op(input logic [4:0] rs, input logic [N-1:0] rdv);
    if (rs == 5'd0) return '0;
    if (BYP && wb_we && wb_rd == rs) return wb_wd;
    return rdv;
  endfunction

  function automatic mdl_t model_next(input mdl_t s);
    mdl_t n;
    n = s;
    if (rst) begin
      n = '{default: '0};
      return n;
    end
    if (!flush && model_hazard(s) && ex_ready && s.cnt != {CNT_W{1'b1}})
      n.cnt = s.cnt + 1'b1;
    if (flush) begin
      n.valid = 1'b0;
    end else if (id_valid && model_ready(s)) begin
      n.valid = 1'b1;
      n.pc    = id_pc;
      n.imm   = id_imm;
      n.op_a  = pick_op(id_rs1, rd1);
      n.op_b  = pick_op(id_rs2, rd2);
      n.rs1   = id_rs1;
      n.rs2   = id_rs2;
      n.rd    = id_rd;
      n.ctrl  = id_ctrl;
      n.rw    = id_reg_write && (id_rd != 5'd0);
    end else if (ex_ready) begin
      n.valid = 1'b0;
    end else if (s.valid && BYP && wb_we && wb_rd != 5'd0) begin
      if (wb_rd == s.rs1) n.op_a = wb_wd;
      if (wb_rd == s.rs2) n.op_b = wb_wd;
    end
    return n;
  endfunction

  task automatic check_outputs();
    check("ex_valid",     64'(ex_valid),     64'(m.valid));
    check("ex_pc",        64'(ex_pc),        64'(m.pc));
    check("ex_imm",       64'(ex_imm),       64'(m.imm));
    check("ex_op_a",      64'(ex_op_a),      64'(m.op_a));
    check("ex_op_b",      64'(ex_op_b),      64'(m.op_b));
    check("ex_rs1",       64'(ex_rs1),       64'(m.rs1));
    check("ex_rs2",       64'(ex_rs2),       64'(m.rs2));
    check("ex_rd",        64'(ex_rd),        64'(m.rd));
    check("ex_ctrl",      64'(ex_ctrl),      64'(m.ctrl));
    check("ex_reg_write", 64'(ex_reg_write), 64'(m.rw));
    check("bubble_cnt",   64'(bubble_cnt),   64'(m.cnt));
  endtask

  // One clock: check id_ready mid-cycle, advance model on the edge, check registers after it
  task automatic step();
    mdl_t nx;
    @(negedge clk);
    check("id_ready", 64'(id_ready), 64'(model_ready(m)));
    nx = model_next(m);
    @(posedge clk);
    #1;
    m = nx;
    check_outputs();
  endtask

  task automatic set_id(input logic v, input logic [N-1:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [N-1:0] imm,
                        input logic [CTRL_W-1:0] ctrl, input logic rw,
                        input logic [N-1:0] r1, input logic [N-1:0] r2);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_imm = imm; id_ctrl = ctrl; id_reg_write = rw; rd1 = r1; rd2 = r2;
  endtask

  localparam logic [CTRL_W-1:0] LOAD = CTRL_W'(1) << MEMRD;

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_wd = '0;
    set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 32'h4, 12'h0, 1'b1, 32'h7, 32'h8);
    @(posedge clk); #1;
    m = '{default: '0};

    // Reset held for two cycles with decode presenting
    step(); step();
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_cnt", 64'(bubble_cnt), 64'd0);
    check("rst_op_a", 64'(ex_op_a), 64'd0);
    rst = 1'b0;

    // Pass-through with an x0 source
    ex_ready = 1'b1;
    set_id(1'b1, 32'h100, 5'd3, 5'd0, 5'd4, 32'h8, 12'h0, 1'b1, 32'h11, 32'hFF);
    step();
    check("pt_valid", 64'(ex_valid), 64'd1);
    check("pt_op_a", 64'(ex_op_a), 64'h11);
    check("pt_op_b", 64'(ex_op_b), 64'h0);

    // Backpressure for three cycles, then release
    ex_ready = 1'b0;
    set_id(1'b1, 32'h104, 5'd1, 5'd2, 5'd0, 32'hC, 12'h0, 1'b1, 32'h21, 32'h22);
    step(); step(); step();
    check("bp_hold_pc", 64'(ex_pc), 64'h100);
    ex_ready = 1'b1;
    step();
    check("bp_accept_pc", 64'(ex_pc), 64'h104);
    check("bp_rw_x0", 64'(ex_reg_write), 64'd0);

    // Load-use: load rd=5 then consumer reading x5
    set_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd5, 32'h0, LOAD, 1'b1, 32'h31, 32'h32);
    step();
    set_id(1'b1, 32'h204, 5'd6, 5'd5, 5'd8, 32'h0, 12'h0, 1'b1, 32'h41, 32'h42);
    step();
    check("lu_bubble_valid", 64'(ex_valid), 64'd0);
    check("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
    step();
    check("lu_consumer_pc", 64'(ex_pc), 64'h204);
    check("lu_consumer_valid", 64'(ex_valid), 64'd1);

    // Load with rd=0 never stalls
    set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd0, 32'h0, LOAD, 1'b1, 32'h51, 32'h52);
    step();
    set_id(1'b1, 32'h304, 5'd0, 5'd0, 5'd9, 32'h0, 12'h0, 1'b1, 32'h61, 32'h62);
    step();
    check("lu_x0_pc", 64'(ex_pc), 64'h304);
    check("lu_x0_cnt", 64'(bubble_cnt), 64'd1);

    // Flush during a hazard: no bubble counted, consumer accepted afterwards
    set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd5, 32'h0, LOAD, 1'b1, 32'h71, 32'h72);
    step();
    set_id(1'b1, 32'h404, 5'd5, 5'd3, 5'd10, 32'h0, 12'h0, 1'b1, 32'h81, 32'h82);
    flush = 1'b1;
    step();
    check("fl_hz_valid", 64'(ex_valid), 64'd0);
    check("fl_hz_cnt", 64'(bubble_cnt), 64'd1);
    flush = 1'b0;
    step();
    check("fl_hz_after_pc", 64'(ex_pc), 64'h404);

    // Flush while an entry is held
    ex_ready = 1'b0; id_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    check("fl_hold_valid", 64'(ex_valid), 64'd0);
    flush = 1'b0;

    // Writeback racing the register read
    ex_ready = 1'b1;
    set_id(1'b1, 32'h500, 5'd7, 5'd2, 5'd9, 32'h0, 12'h0, 1'b1, 32'h1, 32'h22);
    wb_we = 1'b1; wb_rd = 5'd7; wb_wd = 32'hABCD;
    step();
    check("byp_accept_op_a", 64'(ex_op_a), BYP ? 64'hABCD : 64'h1);

    // Writeback landing on a held entry
    ex_ready = 1'b0;
    set_id(1'b1, 32'h504, 5'd1, 5'd1, 5'd1, 32'h0, 12'h0, 1'b1, 32'h3, 32'h3);
    wb_wd = 32'h5555;
    step();
    check("byp_held_op_a", 64'(ex_op_a), BYP ? 64'h5555 : 64'h1);
    check("byp_held_op_b", 64'(ex_op_b), 64'h22);
    wb_we = 1'b0;
    ex_ready = 1'b1;
    step();

    // Random traffic with small register indices to provoke hazards and bypasses
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 8);
      ex_ready = ($urandom_range(0, 99) < 70);
      wb_we    = $urandom_range(0, 1) == 1;
      wb_rd    = 5'($urandom_range(0, 7));
      wb_wd    = $urandom;
      set_id($urandom_range(0, 99) < 75, $urandom, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 1) == 1) ? (CTRL_W'($urandom) | LOAD) : CTRL_W'($urandom) & ~LOAD,
             $urandom_range(0, 1) == 1, $urandom, $urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
